// File: rtl/cpu_pkg.sv
// Shared fetch-path types and default bus widths for the instruction front end.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_INST_W = 16;

  // Fetch sequencer: idle until the first cycle out of reset, then free-running.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  // One prefetched instruction with the address it came from (default widths).
  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, inst} pairs for the fetch queue.
// Clear empties the queue and wins over any push/pop in the same cycle.
module if_fetch_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  input  logic                    i_clear,
  output logic [DATA_W-1:0]       o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Qualify requests against current occupancy.
  always_comb begin
    o_full    = (r_count == CNT_W'(DEPTH));
    o_empty   = (r_count == '0);
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
    o_head    = r_mem[r_rptr];
    o_count   = r_count;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents beyond the count are don't-care.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear && !rst) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generation, ROM drive and a prefetch queue
// presented to decode through valid/ready. A redirect flushes the queue.
// Optional fetch/flush statistics counters are built when IF_FETCH_STATS_EN is defined.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CPU_ADDR_W,
  parameter int unsigned       INST_W   = CPU_INST_W,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rom_ce_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [INST_W-1:0]       rom_data_i,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [ADDR_W-1:0]       id_pc_o,
  output logic [INST_W-1:0]       id_inst_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0]             stat_fetch_o,
  output logic [31:0]             stat_flush_o
`endif
);

  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [ENTRY_W-1:0]  w_head;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave idle on the first cycle out of reset, then run until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch whenever running and there is room; redirect suppresses the push.
  always_comb begin
    rom_ce_o   = (r_state == S_RUN) && !w_full;
    rom_addr_o = r_pc;
    w_push     = rom_ce_o && !redirect_i;
    w_pop      = !w_empty && id_ready_i;
  end

  // PC: redirect target has priority over sequential advance.
  always_ff @(posedge clk) begin
    if (rst)             r_pc <= RESET_PC;
    else if (redirect_i) r_pc <= redirect_pc_i;
    else if (w_push)     r_pc <= r_pc + ADDR_W'(PC_STEP);
  end

  if_fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_pc, rom_data_i}),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .o_head  (w_head),
    .o_count (count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head presentation to decode; zeroed when nothing is buffered.
  always_comb begin
    id_valid_o = !w_empty;
    id_pc_o    = w_empty ? '0 : w_head[ENTRY_W-1:INST_W];
    id_inst_o  = w_empty ? '0 : w_head[INST_W-1:0];
  end

`ifdef IF_FETCH_STATS_EN
  logic w_flush;
  assign w_flush = redirect_i && !w_empty;

  // Saturating counters of pushes and of redirects that dropped buffered work.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_o <= '0;
      stat_flush_o <= '0;
    end else begin
      if (w_push && (stat_fetch_o != 32'hFFFF_FFFF))  stat_fetch_o <= stat_fetch_o + 32'd1;
      if (w_flush && (stat_flush_o != 32'hFFFF_FFFF)) stat_flush_o <= stat_flush_o + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus randomized
// backpressure/redirect traffic against a queue-based reference model.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect;
  logic [15:0] rpc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
  logic [2:0]  count;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] stat_fetch;
  logic [31:0] stat_flush;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy as a queue of pcs, plus fetch pc and run flag.
  bit          m_run = 1'b0;
  logic [15:0] m_q[$];
  logic [15:0] m_pc = 16'h0000;

  always #5 clk = ~clk;

  assign rom_data = rom_addr ^ 16'h3400;

  if_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .count_o       (count)
`ifdef IF_FETCH_STATS_EN
    ,
    .stat_fetch_o  (stat_fetch),
    .stat_flush_o  (stat_flush)
`endif
  );

  function automatic logic [15:0] m_head();
    if (m_q.size() == 0) return 16'h0000;
    return m_q[0];
  endfunction

  function automatic logic m_ce();
    return m_run && (m_q.size() < 4);
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge.
  task automatic cycle();
    bit ce;
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0;
      m_q.delete();
      m_pc = 16'h0000;
    end else begin
      ce = m_ce();
      if ((m_q.size() != 0) && id_ready) void'(m_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_pc = rpc;
      end else if (ce) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 16'd1;
      end
      m_run = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; rpc = 16'h0000; id_ready = ready;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; rpc = 16'h0000; id_ready = 1'b1;
    repeat (4) cycle();
    total++; if (rom_ce !== 1'b0)       begin bad++; $display("FAIL reset_rom_ce got=%b exp=0", rom_ce); end
    total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL reset_rom_addr got=%h exp=0000", rom_addr); end
    total++; if (id_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    total++; if (id_pc !== 16'h0000)    begin bad++; $display("FAIL reset_id_pc got=%h exp=0000", id_pc); end
    total++; if (id_inst !== 16'h0000)  begin bad++; $display("FAIL reset_id_inst got=%h exp=0000", id_inst); end
    total++; if (count !== 3'd0)        begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 1'b0;
    #1;
    total++; if (rom_ce !== 1'b0) begin bad++; $display("FAIL start_c0_rom_ce got=%b exp=0", rom_ce); end
    cycle();
    total++; if (rom_ce !== 1'b1)   begin bad++; $display("FAIL start_c1_rom_ce got=%b exp=1", rom_ce); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL start_c1_valid got=%b exp=0", id_valid); end
    cycle();
    total++; if (id_valid !== 1'b1)    begin bad++; $display("FAIL start_c2_valid got=%b exp=1", id_valid); end
    total++; if (id_pc !== 16'h0000)   begin bad++; $display("FAIL start_c2_pc got=%h exp=0000", id_pc); end
    total++; if (id_inst !== 16'h3400) begin bad++; $display("FAIL start_c2_inst got=%h exp=3400", id_inst); end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      total++;
      if ((id_valid !== 1'b1) || (id_pc !== 16'(i)) || (id_inst !== (16'(i) ^ 16'h3400))) begin
        bad++; $display("FAIL start_stream v=%b pc=%h inst=%h exp_pc=%h", id_valid, id_pc, id_inst, 16'(i));
      end
    end
  endtask

  task automatic test_fill();
    logic [15:0] exp_pc;
    int n;
    do_reset(1'b0);
    repeat (8) cycle();
    total++; if (count !== 3'd4)        begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (rom_ce !== 1'b0)       begin bad++; $display("FAIL fill_rom_ce got=%b exp=0", rom_ce); end
    total++; if (rom_addr !== 16'h0004) begin bad++; $display("FAIL fill_rom_addr got=%h exp=0004", rom_addr); end
    id_ready = 1'b1;
    exp_pc = 16'h0000; n = 0;
    for (int k = 0; k < 20 && n < 6; k++) begin
      if (id_valid) begin
        total++;
        if (id_pc !== exp_pc) begin bad++; $display("FAIL fill_drain_pc got=%h exp=%h", id_pc, exp_pc); end
        exp_pc = exp_pc + 16'd1; n++;
      end
      cycle();
    end
    total++; if (n != 6) begin bad++; $display("FAIL fill_drain_timeout got=%0d exp=6", n); end
  endtask

  task automatic test_redirect();
`ifdef IF_FETCH_STATS_EN
    logic [31:0] flush0;
`endif
    do_reset(1'b0);
    repeat (8) cycle();
    id_ready = 1'b1; repeat (2) cycle();
    id_ready = 1'b0; repeat (3) cycle();
    total++; if (count !== 3'd4)     begin bad++; $display("FAIL redir_pre_count got=%0d exp=4", count); end
    total++; if (id_pc !== 16'h0002) begin bad++; $display("FAIL redir_pre_head got=%h exp=0002", id_pc); end
`ifdef IF_FETCH_STATS_EN
    flush0 = stat_flush;
`endif
    redirect = 1'b1; rpc = 16'h0040;
    cycle();
    redirect = 1'b0;
    #1;
    total++; if (count !== 3'd0)        begin bad++; $display("FAIL redir_count got=%0d exp=0", count); end
    total++; if (rom_addr !== 16'h0040) begin bad++; $display("FAIL redir_rom_addr got=%h exp=0040", rom_addr); end
    total++; if (id_valid !== 1'b0)     begin bad++; $display("FAIL redir_valid got=%b exp=0", id_valid); end
    cycle();
    total++; if (id_valid !== 1'b1)    begin bad++; $display("FAIL redir_n2_valid got=%b exp=1", id_valid); end
    total++; if (id_pc !== 16'h0040)   begin bad++; $display("FAIL redir_n2_pc got=%h exp=0040", id_pc); end
    total++; if (id_inst !== 16'h3440) begin bad++; $display("FAIL redir_n2_inst got=%h exp=3440", id_inst); end
`ifdef IF_FETCH_STATS_EN
    total++; if (stat_flush !== flush0 + 32'd1) begin bad++; $display("FAIL redir_stat_flush got=%0d exp=%0d", stat_flush, flush0 + 32'd1); end
`endif
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pcs [4];
    int n;
    exp_pcs[0] = 16'hFFFE; exp_pcs[1] = 16'hFFFF; exp_pcs[2] = 16'h0000; exp_pcs[3] = 16'h0001;
    id_ready = 1'b1; redirect = 1'b1; rpc = 16'hFFFE;
    cycle();
    redirect = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (id_valid) begin
        total++;
        if (id_pc !== exp_pcs[n]) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", id_pc, exp_pcs[n]); end
        n++;
      end
      cycle();
    end
    total++; if (n != 4) begin bad++; $display("FAIL wrap_timeout got=%0d exp=4", n); end
  endtask

  task automatic test_random();
    logic [15:0] last_pc;
    bit          have_last;
    int          errs;
    do_reset(1'b0);
    have_last = 1'b0;
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      id_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 59) == 0);
      rpc      = 16'($urandom);
      #1;
      total++; if (count !== 3'(m_q.size())) begin bad++; errs++; if (errs < 10) $display("FAIL rand_count got=%0d exp=%0d", count, m_q.size()); end
      total++; if (count > 3'd4)             begin bad++; errs++; if (errs < 10) $display("FAIL rand_count_max got=%0d exp<=4", count); end
      total++; if (id_valid !== (m_q.size() != 0)) begin bad++; errs++; if (errs < 10) $display("FAIL rand_valid got=%b exp=%b", id_valid, m_q.size() != 0); end
      total++; if (id_pc !== m_head())      begin bad++; errs++; if (errs < 10) $display("FAIL rand_pc got=%h exp=%h", id_pc, m_head()); end
      total++; if ((m_q.size() != 0) && (id_inst !== (m_head() ^ 16'h3400))) begin bad++; errs++; if (errs < 10) $display("FAIL rand_inst got=%h exp=%h", id_inst, m_head() ^ 16'h3400); end
      total++; if (rom_ce !== m_ce())       begin bad++; errs++; if (errs < 10) $display("FAIL rand_rom_ce got=%b exp=%b", rom_ce, m_ce()); end
      total++; if (rom_addr !== m_pc)       begin bad++; errs++; if (errs < 10) $display("FAIL rand_rom_addr got=%h exp=%h", rom_addr, m_pc); end
      if (id_valid && id_ready) begin
        if (have_last) begin
          total++;
          if (id_pc !== last_pc + 16'd1) begin bad++; errs++; if (errs < 10) $display("FAIL rand_consecutive got=%h exp=%h", id_pc, last_pc + 16'd1); end
        end
        last_pc = id_pc; have_last = 1'b1;
      end
      if (redirect) have_last = 1'b0;
      cycle();
    end
    redirect = 1'b0;
  endtask

  task automatic test_midreset();
    int k;
    do_reset(1'b0);
    k = 0;
    while ((count !== 3'd3) && (k < 10)) begin cycle(); k++; end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_reach3 got=%0d exp=3", count); end
    rst = 1'b1; id_ready = 1'b1;
    cycle();
    total++; if (count !== 3'd0)        begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (id_valid !== 1'b0)     begin bad++; $display("FAIL mid_valid got=%b exp=0", id_valid); end
    total++; if (rom_ce !== 1'b0)       begin bad++; $display("FAIL mid_rom_ce got=%b exp=0", rom_ce); end
    total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL mid_rom_addr got=%h exp=0000", rom_addr); end
    total++; if ((id_pc !== 16'h0000) || (id_inst !== 16'h0000)) begin bad++; $display("FAIL mid_head got=%h/%h exp=0000/0000", id_pc, id_inst); end
    rst = 1'b0;
    #1;
    total++; if (rom_ce !== 1'b0) begin bad++; $display("FAIL mid_c0_rom_ce got=%b exp=0", rom_ce); end
    cycle();
    total++; if ((rom_ce !== 1'b1) || (rom_addr !== 16'h0000)) begin bad++; $display("FAIL mid_c1 ce=%b addr=%h exp=1/0000", rom_ce, rom_addr); end
    cycle();
    total++; if ((id_valid !== 1'b1) || (id_pc !== 16'h0000) || (id_inst !== 16'h3400)) begin bad++; $display("FAIL mid_c2 v=%b pc=%h inst=%h exp=1/0000/3400", id_valid, id_pc, id_inst); end
    cycle();
    total++; if (id_pc !== 16'h0001) begin bad++; $display("FAIL mid_c3_pc got=%h exp=0001", id_pc); end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; rpc = 16'h0000; id_ready = 1'b1;
    test_reset();
    test_fill();
    test_redirect();
    test_wrap();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
